cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Two-requester arbiter that shares the core's single memory bus between the memory stage (data requester, D) and the fetch stage (instruction requester, I).
- Sits between the fetch/memory pipeline stages and the external bus port.
- Grants one requester at a time and holds the grant for the full burst.
- Prioritises D, and uses a starvation counter so that I cannot be locked out.

Parameters:
- STARVE_LIMIT, 4: number of consecutive D grants allowed while I is waiting before I is forced to win.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dreq  input  145  D request, packed MSB-first: valid(1), is_write(1), size(3), len(4; beats-1), strobe(8), addr(64), wdata(64).
- dresp  output  66  D response, packed MSB-first: ready(1), last(1), rdata(64).
- ireq  input  145  I request, same packing as dreq.
- iresp  output  66  I response, same packing as dresp.
- oreq  output  145  downstream request, same packing.
- oresp  input  66  downstream response, same packing.
- busy  output  1  a transaction is currently owned.
- owner  output  1  current owner: 0 = D, 1 = I. Valid only while busy.

Behaviour:
- States: IDLE, GRANT_D, GRANT_I. Registers: state, starve_cnt[CNT_W-1:0], beat_cnt[3:0].
- Reset (asynchronous, any cycle, including mid-burst):
  - state = IDLE, starve_cnt = 0, beat_cnt = 0.
  - All outputs are 0: oreq = 0, dresp = 0, iresp = 0, busy = 0, owner = 0.
  - An in-flight transaction is abandoned; requesters re-issue after reset.
- IDLE:
  - oreq = 0; dresp and iresp are 0.
  - The winner is evaluated from the valid bits in the current cycle.
  - Only D valid -> GRANT_D.
  - Only I valid -> GRANT_I.
  - Both valid: if starve_cnt == STARVE_LIMIT -> GRANT_I, otherwise -> GRANT_D.
  - Neither valid -> stay in IDLE.
  - Grant latency is exactly 1 cycle: a request sampled in cycle N appears on oreq in cycle N+1.
- GRANT_x (x = D or I):
  - oreq = xreq, combinational pass-through.
  - xresp = oresp, combinational pass-through.
  - The other requester's response is 0; its ready is never asserted.
- Beat counting:
  - beat_cnt increments on each oresp.ready.
  - The transaction ends on oresp.ready && oresp.last. Then state -> IDLE and beat_cnt = 0.
  - No back-to-back grant: at least one IDLE cycle always occurs between transactions.
- Protocol checker (simulation only, does not affect RTL behaviour):
  - Flags oresp.last arriving when beat_cnt != the owner's len.
  - Flags oresp.last missing once beat_cnt has passed len.
- Requester obligation: xreq must stay valid and stable from grant until the last beat. The arbiter does not re-check valid while granted, and a dropped valid is a protocol violation.
- Starvation counter, updated on the IDLE->GRANT transition:
  - GRANT_D taken while I valid: starve_cnt += 1, saturating at STARVE_LIMIT.
  - GRANT_I taken: starve_cnt = 0.
  - GRANT_D taken with I not valid: starve_cnt = 0.
- Outputs:
  - busy = (state != IDLE).
  - owner = (state == GRANT_I).
- Simultaneous events: D and I asserting valid in the same cycle as the last beat are not seen until IDLE. Arbitration happens in that IDLE cycle.

Test Plan:
1. Reset asserted with no requests -> all outputs 0 and state IDLE. Drive reset high for 2 cycles mid-burst -> outputs 0 immediately (asynchronous), and no ready pulse reaches the former owner.
2. Lone D single-beat read (addr=0x8000_0000, len=0) at cycle 0, downstream ready+last with rdata=0xDEAD_BEEF at cycle 3 -> oreq matches dreq from cycle 1; dresp.rdata=0xDEAD_BEEF at cycle 3; busy falls at cycle 4; iresp stays 0 throughout.
3. D and I both valid at cycle 0, starve_cnt=0 -> D granted (owner=0). After D's last beat, I is granted after exactly one IDLE cycle.
4. D kept continuously valid with I valid, STARVE_LIMIT=4 -> D wins 4 grants (starve_cnt 1..4), the 5th grant goes to I, and starve_cnt then returns to 0.
5. I burst with len=3 (4 beats), downstream asserts ready on beats 0-3 with gaps of 0/2/1 stall cycles and last on beat 3 -> 4 ready pulses reach iresp in order, dresp stays 0, release follows the 4th beat, and the checker reports no error.
6. Downstream asserts last on beat 1 of a len=3 burst -> arbiter releases to IDLE after beat 1 and the protocol checker reports a length mismatch.

Source files
------------

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - two-requester memory bus arbiter, data-priority with instruction anti-starvation
// Grants hold for the whole burst; an IDLE cycle always separates two transactions.
module cbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [144:0] dreq,
  output logic [65:0]  dresp,
  input  logic [144:0] ireq,
  output logic [65:0]  iresp,
  output logic [144:0] oreq,
  input  logic [65:0]  oresp,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [3:0]       beat_cnt_q;
  logic             len_err_q;

  logic       d_valid, i_valid, starve_full, rsp_ready, rsp_last;
  logic [3:0] cur_len;

  assign d_valid     = dreq[144];
  assign i_valid     = ireq[144];
  assign starve_full = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign rsp_ready   = oresp[65];
  assign rsp_last    = oresp[64];
  assign cur_len     = oreq[139:136];

  assign busy  = (state_q != IDLE);
  assign owner = (state_q == GRANT_I);

  // The non-owner never sees the downstream response, so it can never observe ready.
  always_comb begin
    oreq  = '0;
    dresp = '0;
    iresp = '0;
    case (state_q)
      GRANT_D: begin
        oreq  = dreq;
        dresp = oresp;
      end
      GRANT_I: begin
        oreq  = ireq;
        iresp = oresp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (d_valid && !(i_valid && starve_full)) begin
            state_q <= GRANT_D;
            if (!i_valid) begin
              starve_cnt_q <= '0;
            end else if (!starve_full) begin
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
          end else if (i_valid) begin
            state_q      <= GRANT_I;
            starve_cnt_q <= '0;
          end
        end
        GRANT_D, GRANT_I: begin
          // len_err_q is a sticky burst-length sanity flag for simulation; it drives nothing.
          if (rsp_ready) begin
            if (rsp_last) begin
              state_q    <= IDLE;
              beat_cnt_q <= '0;
              if (beat_cnt_q != cur_len) len_err_q <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
              if (beat_cnt_q >= cur_len) len_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed self-checking bench for cbus_arbiter
// Inputs change just after the falling edge and outputs are checked 1ns later.
module tb_cbus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [144:0] dreq, ireq, oreq;
  logic [65:0]  dresp, iresp, oresp;
  logic         busy, owner;

  int checks = 0;
  int errors = 0;

  logic [144:0] d_rd, i_rd, d_b4, i_b4;
  logic [65:0]  rsp;
  int           gap [4];

  cbus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .dreq(dreq), .dresp(dresp),
    .ireq(ireq), .iresp(iresp),
    .oreq(oreq), .oresp(oresp),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [144:0] mkreq(input logic [3:0] len, input logic [63:0] addr,
                                         input logic [63:0] wdata);
    return {1'b1, 1'b0, 3'd3, len, 8'hFF, addr, wdata};
  endfunction

  function automatic logic [65:0] mkrsp(input logic last, input logic [63:0] rdata);
    return {1'b1, last, rdata};
  endfunction

  task automatic chk_req(input string tag, input logic [144:0] obs, input logic [144:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    d_rd = mkreq(4'd0, 64'h8000_0000, 64'h0);
    i_rd = mkreq(4'd0, 64'h0000_1000, 64'h0);
    i_b4 = mkreq(4'd3, 64'h0000_2000, 64'h0);
    d_b4 = mkreq(4'd3, 64'h0000_3000, 64'h0);
    gap  = '{0, 0, 2, 1};

    // 1. reset with no requests
    reset = 1'b1; dreq = '0; ireq = '0; oresp = '0;
    next_cyc(); next_cyc(); #1;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_owner", owner, 1'b0);
    chk_req("rst_oreq", oreq, '0);
    chk_rsp("rst_dresp", dresp, '0);
    chk_rsp("rst_iresp", iresp, '0);
    reset = 1'b0;

    // 2. lone D single-beat read
    next_cyc(); dreq = d_rd; #1;
    chk_req("d1_c0_oreq", oreq, '0);
    chk_bit("d1_c0_busy", busy, 1'b0);
    next_cyc(); #1;
    chk_req("d1_c1_oreq", oreq, d_rd);
    chk_bit("d1_c1_busy", busy, 1'b1);
    chk_bit("d1_c1_owner", owner, 1'b0);
    next_cyc(); #1;
    chk_req("d1_c2_oreq", oreq, d_rd);
    chk_rsp("d1_c2_dresp", dresp, '0);
    next_cyc(); oresp = mkrsp(1'b1, 64'hDEAD_BEEF); #1;
    chk_rsp("d1_c3_dresp", dresp, {2'b11, 64'hDEAD_BEEF});
    chk_rsp("d1_c3_iresp", iresp, '0);
    next_cyc(); dreq = '0; oresp = '0; #1;
    chk_bit("d1_c4_busy", busy, 1'b0);
    chk_req("d1_c4_oreq", oreq, '0);

    // 3. D and I together: D first, then I after one IDLE cycle
    next_cyc(); dreq = d_rd; ireq = i_rd; #1;
    next_cyc(); #1;
    chk_bit("both_owner_d", owner, 1'b0);
    chk_req("both_oreq_d", oreq, d_rd);
    oresp = mkrsp(1'b1, 64'h1111); #1;
    chk_rsp("both_iresp_quiet", iresp, '0);
    next_cyc(); dreq = '0; oresp = '0; #1;
    chk_bit("both_idle_gap", busy, 1'b0);
    chk_req("both_idle_oreq", oreq, '0);
    next_cyc(); #1;
    chk_bit("both_owner_i", owner, 1'b1);
    chk_req("both_oreq_i", oreq, i_rd);
    chk_rsp("both_starve", 66'(dut.starve_cnt_q), 66'd0);
    oresp = mkrsp(1'b1, 64'h2222); #1;
    chk_rsp("both_iresp", iresp, {2'b11, 64'h2222});
    chk_rsp("both_dresp_quiet", dresp, '0);
    next_cyc(); ireq = '0; oresp = '0; #1;
    chk_bit("both_release", busy, 1'b0);

    // 4. anti-starvation: four D grants, then I, counter back to 0
    next_cyc(); dreq = d_rd; ireq = i_rd; #1;
    for (int k = 0; k < 5; k++) begin
      chk_bit($sformatf("starve_idle_%0d", k), busy, 1'b0);
      next_cyc(); #1;
      chk_bit($sformatf("starve_owner_%0d", k), owner, (k == 4));
      chk_rsp($sformatf("starve_cnt_%0d", k), 66'(dut.starve_cnt_q),
              (k == 4) ? 66'd0 : 66'(k + 1));
      oresp = mkrsp(1'b1, 64'h0); #1;
      next_cyc(); oresp = '0; #1;
    end
    dreq = '0; ireq = '0;

    // 5. I burst of 4 beats with stalls 0/2/1
    next_cyc(); ireq = i_b4; #1;
    next_cyc(); #1;
    chk_bit("burst_owner", owner, 1'b1);
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < gap[b]; s++) begin
        oresp = '0; #1;
        chk_rsp($sformatf("burst_stall_%0d_%0d", b, s), iresp, '0);
        chk_bit($sformatf("burst_busy_%0d_%0d", b, s), busy, 1'b1);
        next_cyc();
      end
      oresp = mkrsp(b == 3, 64'hA0 + 64'(b)); #1;
      chk_rsp($sformatf("burst_beat_%0d", b), iresp, {1'b1, (b == 3), 64'hA0 + 64'(b)});
      chk_rsp($sformatf("burst_dresp_%0d", b), dresp, '0);
      next_cyc();
    end
    ireq = '0; oresp = '0; #1;
    chk_bit("burst_release", busy, 1'b0);
    chk_bit("burst_no_len_err", dut.len_err_q, 1'b0);

    // 6. early last on beat 1 of a 4-beat burst
    next_cyc(); dreq = d_b4; #1;
    next_cyc(); oresp = mkrsp(1'b0, 64'h5); #1;
    chk_bit("early_owner", owner, 1'b0);
    next_cyc(); oresp = mkrsp(1'b1, 64'h6); #1;
    chk_rsp("early_last_dresp", dresp, {2'b11, 64'h6});
    chk_bit("early_no_err_yet", dut.len_err_q, 1'b0);
    next_cyc(); dreq = '0; oresp = '0; #1;
    chk_bit("early_release", busy, 1'b0);
    chk_bit("early_len_err", dut.len_err_q, 1'b1);

    // 1b. asynchronous reset in the middle of a burst
    next_cyc(); dreq = d_b4; #1;
    next_cyc(); oresp = mkrsp(1'b0, 64'h7); #1;
    chk_bit("mid_busy_pre", busy, 1'b1);
    #1 reset = 1'b1; #1;
    chk_bit("mid_busy_async", busy, 1'b0);
    chk_req("mid_oreq_async", oreq, '0);
    chk_rsp("mid_dresp_async", dresp, '0);
    next_cyc(); #1;
    chk_rsp("mid_dresp_held", dresp, '0);
    next_cyc(); dreq = '0; oresp = '0; reset = 1'b0; #1;
    chk_bit("mid_busy_post", busy, 1'b0);
    chk_bit("mid_len_err_clr", dut.len_err_q, 1'b0);
    next_cyc(); #1;
    chk_bit("mid_stays_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
